// File: rtl/pcie_tx_sched_pkg.sv
// Shared types for the PCIe TX link scheduler: FSM states and tx_sel encodings.
// No logic, no latency.
package pcie_tx_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OS   = 2'd1,
        ST_SKP  = 2'd2,
        ST_DATA = 2'd3
    } sched_state_t;

    localparam logic [1:0] SEL_IDLE = 2'd0;
    localparam logic [1:0] SEL_OS   = 2'd1;
    localparam logic [1:0] SEL_SKP  = 2'd2;
    localparam logic [1:0] SEL_DATA = 2'd3;

    function automatic logic [1:0] state_to_sel(input sched_state_t st);
        logic [1:0] sel;
        sel = SEL_IDLE;
        case (st)
            ST_OS:   sel = SEL_OS;
            ST_SKP:  sel = SEL_SKP;
            ST_DATA: sel = SEL_DATA;
            default: sel = SEL_IDLE;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/skp_interval_timer.sv
// SKP interval timer: counts active clocks and raises skp_pending one clock after reaching SKP_INTERVAL-1.
// Counter saturates while a SKP is deferred; clr (SKP entry) restarts it. No backpressure.
module skp_interval_timer #(
    parameter int SKP_INTERVAL = 1180,
    parameter int CNT_W        = 12
) (
    input  logic CLK,
    input  logic lpreset,
    input  logic run,
    input  logic clr,
    output logic skp_pending
);

    localparam logic [CNT_W-1:0] LP_SAT = CNT_W'(SKP_INTERVAL - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_pend;

    // Holding at LP_SAT means a long packet can only ever owe one SKP.
    always_ff @(posedge CLK or negedge lpreset) begin
        if (!lpreset) begin
            r_cnt  <= '0;
            r_pend <= 1'b0;
        end else if (clr) begin
            r_cnt  <= '0;
            r_pend <= 1'b0;
        end else if (run) begin
            if (r_cnt == LP_SAT) begin
                r_pend <= 1'b1;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign skp_pending = r_pend;

endmodule

// File: rtl/tx_link_scheduler.sv
// Arbitrates the TX lane datapath between training OS, SKP OS and LPIF beats; slots switch only at packet boundaries.
// Select/pulses are registered-state decodes; pl_trdy is combinational and drops in the switch cycle.
module tx_link_scheduler
    import pcie_tx_sched_pkg::*;
#(
    parameter int SKP_INTERVAL = 1180,
    parameter int SKP_CYCLES   = 1,
    parameter int OS_CYCLES    = 4,
    parameter int CNT_W        = 12
) (
    input  logic       CLK,
    input  logic       lpreset,
    input  logic       linkUp,
    input  logic       os_req,
    input  logic       lp_irdy,
    input  logic       lp_pkt_start,
    input  logic       lp_pkt_end,
    output logic       pl_trdy,
    output logic [1:0] tx_sel,
    output logic       os_gnt,
    output logic       os_done,
    output logic       skp_insert
);

    localparam int SLOT_MAX = (OS_CYCLES > SKP_CYCLES) ? OS_CYCLES : SKP_CYCLES;
    localparam int SLOT_W   = (SLOT_MAX > 1) ? $clog2(SLOT_MAX) : 1;

    localparam logic [SLOT_W-1:0] OS_LAST  = SLOT_W'(OS_CYCLES - 1);
    localparam logic [SLOT_W-1:0] SKP_LAST = SLOT_W'(SKP_CYCLES - 1);

    sched_state_t      r_state;
    sched_state_t      w_nxt_state;
    logic [SLOT_W-1:0] r_slot_cnt;
    logic              r_in_pkt;

    logic w_skp_pending;
    logic w_bnd;
    logic w_trdy;
    logic w_accept;
    logic w_pkt_done;
    logic w_slot_last;
    logic w_at_bnd;
    logic w_skp_clr;
    logic w_run;

    assign w_bnd      = !r_in_pkt;
    assign w_trdy     = (r_state == ST_DATA) && linkUp &&
                        !(w_bnd && (w_skp_pending || os_req));
    assign w_accept   = lp_irdy && w_trdy;
    assign w_pkt_done = w_accept && lp_pkt_end;

    assign w_slot_last = ((r_state == ST_OS)  && (r_slot_cnt == OS_LAST)) ||
                         ((r_state == ST_SKP) && (r_slot_cnt == SKP_LAST));

    // The end beat itself is a boundary, so a deferred slot starts right after it.
    assign w_at_bnd = (r_state == ST_IDLE) || w_slot_last ||
                      ((r_state == ST_DATA) && (w_bnd || w_pkt_done));

    always_comb begin
        w_nxt_state = r_state;
        if ((r_state == ST_DATA) && !linkUp) begin
            w_nxt_state = os_req ? ST_OS : ST_IDLE;
        end else if (w_at_bnd) begin
            if (w_skp_pending && (r_state != ST_IDLE)) begin
                w_nxt_state = ST_SKP;
            end else if (os_req) begin
                w_nxt_state = ST_OS;
            end else if (linkUp) begin
                w_nxt_state = ST_DATA;
            end else begin
                w_nxt_state = ST_IDLE;
            end
        end
    end

    always_ff @(posedge CLK or negedge lpreset) begin
        if (!lpreset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nxt_state;
        end
    end

    // Slot counter restarts on the last cycle so back-to-back OS slots need no gap.
    always_ff @(posedge CLK or negedge lpreset) begin
        if (!lpreset) begin
            r_slot_cnt <= '0;
        end else if (((r_state == ST_OS) || (r_state == ST_SKP)) && !w_slot_last) begin
            r_slot_cnt <= r_slot_cnt + 1'b1;
        end else begin
            r_slot_cnt <= '0;
        end
    end

    always_ff @(posedge CLK or negedge lpreset) begin
        if (!lpreset) begin
            r_in_pkt <= 1'b0;
        end else if (!linkUp) begin
            r_in_pkt <= 1'b0;
        end else if (w_pkt_done) begin
            r_in_pkt <= 1'b0;
        end else if (w_accept && lp_pkt_start) begin
            r_in_pkt <= 1'b1;
        end
    end

    assign w_run     = (r_state != ST_IDLE);
    assign w_skp_clr = (w_nxt_state == ST_SKP) && (r_state != ST_SKP);

    skp_interval_timer #(
        .SKP_INTERVAL (SKP_INTERVAL),
        .CNT_W        (CNT_W)
    ) u_skp_timer (
        .CLK         (CLK),
        .lpreset     (lpreset),
        .run         (w_run),
        .clr         (w_skp_clr),
        .skp_pending (w_skp_pending)
    );

    assign pl_trdy    = w_trdy;
    assign tx_sel     = state_to_sel(r_state);
    assign os_gnt     = (r_state == ST_OS)  && (r_slot_cnt == '0);
    assign os_done    = (r_state == ST_OS)  && (r_slot_cnt == OS_LAST);
    assign skp_insert = (r_state == ST_SKP) && (r_slot_cnt == '0);

endmodule

// File: tb/tb_tx_link_scheduler.sv
// Scoreboard bench for tx_link_scheduler with a 16-clock SKP interval.
module tb_tx_link_scheduler;

    logic       CLK = 1'b0;
    logic       lpreset;
    logic       linkUp;
    logic       os_req;
    logic       lp_irdy;
    logic       lp_pkt_start;
    logic       lp_pkt_end;
    logic       pl_trdy;
    logic [1:0] tx_sel;
    logic       os_gnt;
    logic       os_done;
    logic       skp_insert;

    typedef struct packed {
        logic [1:0] sel;
        logic       trdy;
        logic       gnt;
        logic       done;
        logic       skp;
    } want_t;

    want_t sb[$];
    int    vec_cnt = 0;
    int    err_cnt = 0;
    int    beats   = 0;
    int    skps    = 0;

    tx_link_scheduler #(
        .SKP_INTERVAL (16),
        .SKP_CYCLES   (1),
        .OS_CYCLES    (4),
        .CNT_W        (12)
    ) dut (
        .CLK          (CLK),
        .lpreset      (lpreset),
        .linkUp       (linkUp),
        .os_req       (os_req),
        .lp_irdy      (lp_irdy),
        .lp_pkt_start (lp_pkt_start),
        .lp_pkt_end   (lp_pkt_end),
        .pl_trdy      (pl_trdy),
        .tx_sel       (tx_sel),
        .os_gnt       (os_gnt),
        .os_done      (os_done),
        .skp_insert   (skp_insert)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input int obs, input int want);
        vec_cnt++;
        if (obs != want) begin
            err_cnt++;
            $display("FAIL %s: got %0d, want %0d", tag, obs, want);
        end
    endtask

    function automatic want_t w(input int sel, input bit trdy, input bit gnt,
                                input bit done, input bit skp);
        want_t r;
        r.sel  = 2'(sel);
        r.trdy = trdy;
        r.gnt  = gnt;
        r.done = done;
        r.skp  = skp;
        return r;
    endfunction

    // One clock: drive inputs after the edge, queue the expectation, check at the falling edge.
    task automatic cyc(input string tag, input bit rn, input bit lu, input bit oq,
                       input bit irdy, input bit st, input bit en, input want_t e);
        want_t x;
        @(posedge CLK);
        #1;
        lpreset      = rn;
        linkUp       = lu;
        os_req       = oq;
        lp_irdy      = irdy;
        lp_pkt_start = st;
        lp_pkt_end   = en;
        sb.push_back(e);
        @(negedge CLK);
        x = sb.pop_front();
        chk({tag, ".sel"},  int'(tx_sel),     int'(x.sel));
        chk({tag, ".trdy"}, int'(pl_trdy),    int'(x.trdy));
        chk({tag, ".gnt"},  int'(os_gnt),     int'(x.gnt));
        chk({tag, ".done"}, int'(os_done),    int'(x.done));
        chk({tag, ".skp"},  int'(skp_insert), int'(x.skp));
        if (pl_trdy && lp_irdy) beats++;
        if (skp_insert) skps++;
    endtask

    task automatic do_reset();
        cyc("rst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, w(0, 0, 0, 0, 0));
        beats = 0;
        skps  = 0;
    endtask

    initial begin
        lpreset      = 1'b0;
        linkUp       = 1'b0;
        os_req       = 1'b0;
        lp_irdy      = 1'b0;
        lp_pkt_start = 1'b0;
        lp_pkt_end   = 1'b0;

        // Reset holds everything low even with requests present.
        cyc("rst0", 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, w(0, 0, 0, 0, 0));
        cyc("rst1", 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, w(0, 0, 0, 0, 0));

        // Training: three back-to-back OS slots with the link down.
        for (int k = 0; k <= 13; k++) begin
            want_t e;
            if (k == 0 || k == 13) e = w(0, 0, 0, 0, 0);
            else e = w(1, 0, ((k - 1) % 4) == 0, (k % 4) == 0, 0);
            cyc($sformatf("trn%0d", k), 1'b1, 1'b0, k < 12, 1'b0, 1'b0, 1'b0, e);
        end

        // Reset asserted in the second OS cycle, then a fresh request.
        do_reset();
        cyc("ro0", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, w(0, 0, 0, 0, 0));
        cyc("ro1", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, w(1, 0, 1, 0, 0));
        cyc("ro2", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, w(0, 0, 0, 0, 0));
        cyc("ro3", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, w(0, 0, 0, 0, 0));
        cyc("ro4", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, w(1, 0, 1, 0, 0));
        cyc("ro5", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, w(1, 0, 0, 0, 0));
        cyc("ro6", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, w(1, 0, 0, 0, 0));
        cyc("ro7", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, w(1, 0, 0, 1, 0));
        cyc("ro8", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, w(0, 0, 0, 0, 0));

        // Periodic SKP with a single-beat packet offered every clock.
        do_reset();
        for (int k = 0; k <= 55; k++) begin
            want_t e;
            bit    is_skp, is_sw;
            is_skp = (k >= 18) && (((k - 18) % 17) == 0);
            is_sw  = (k >= 17) && (((k - 17) % 17) == 0);
            if (k == 0) e = w(0, 0, 0, 0, 0);
            else e = w(is_skp ? 2 : 3, !(is_skp || is_sw), 0, 0, is_skp);
            cyc($sformatf("per%0d", k), 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, e);
        end
        chk("per.beats", beats, 49);
        chk("per.skps", skps, 3);

        // A 10-beat packet straddling the SKP due point defers the SKP to its end.
        do_reset();
        for (int k = 0; k <= 40; k++) begin
            want_t e;
            if (k == 0) e = w(0, 0, 0, 0, 0);
            else if (k == 25) e = w(2, 0, 0, 0, 1);
            else e = w(3, 1, 0, 0, 0);
            cyc($sformatf("dfr%0d", k), 1'b1, 1'b1, 1'b0,
                (k >= 15) && (k <= 24), k == 15, k == 24, e);
        end
        chk("dfr.beats", beats, 10);
        chk("dfr.skps", skps, 1);

        // SKP and OS requested at the same boundary: SKP, then OS, then data.
        do_reset();
        for (int k = 0; k <= 24; k++) begin
            want_t e;
            if (k == 0)                   e = w(0, 0, 0, 0, 0);
            else if (k <= 16)             e = w(3, 1, 0, 0, 0);
            else if (k == 17)             e = w(3, 0, 0, 0, 0);
            else if (k == 18)             e = w(2, 0, 0, 0, 1);
            else if (k == 19)             e = w(1, 0, 1, 0, 0);
            else if (k == 22)             e = w(1, 0, 0, 1, 0);
            else if (k <= 21)             e = w(1, 0, 0, 0, 0);
            else                          e = w(3, 1, 0, 0, 0);
            cyc($sformatf("col%0d", k), 1'b1, 1'b1, (k == 17) || (k == 18),
                1'b0, 1'b0, 1'b0, e);
        end

        // Link drop on beat 3 of a 6-beat packet, no OS request pending.
        do_reset();
        cyc("ld0", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, w(0, 0, 0, 0, 0));
        cyc("ld1", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, w(3, 1, 0, 0, 0));
        cyc("ld2", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, w(3, 1, 0, 0, 0));
        cyc("ld3", 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, w(3, 1, 0, 0, 0));
        cyc("ld4", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, w(3, 1, 0, 0, 0));
        cyc("ld5", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, w(3, 0, 0, 0, 0));
        cyc("ld6", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, w(0, 0, 0, 0, 0));
        cyc("ld7", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, w(0, 0, 0, 0, 0));
        cyc("ld8", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, w(3, 0, 0, 0, 0));
        cyc("ld9", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, w(1, 0, 1, 0, 0));
        chk("ld.beats", beats, 2);

        // Same drop with an OS request: training OS follows directly.
        do_reset();
        cyc("lo0",  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, w(0, 0, 0, 0, 0));
        cyc("lo1",  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, w(3, 1, 0, 0, 0));
        cyc("lo2",  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, w(3, 1, 0, 0, 0));
        cyc("lo3",  1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, w(3, 1, 0, 0, 0));
        cyc("lo4",  1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, w(3, 1, 0, 0, 0));
        cyc("lo5",  1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, w(3, 0, 0, 0, 0));
        cyc("lo6",  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, w(1, 0, 1, 0, 0));
        cyc("lo7",  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, w(1, 0, 0, 0, 0));
        cyc("lo8",  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, w(1, 0, 0, 0, 0));
        cyc("lo9",  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, w(1, 0, 0, 1, 0));
        cyc("lo10", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, w(0, 0, 0, 0, 0));
        cyc("lo11", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, w(3, 1, 0, 0, 0));
        cyc("lo12", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, w(3, 0, 0, 0, 0));
        cyc("lo13", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, w(1, 0, 1, 0, 0));
        chk("lo.beats", beats, 2);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/tx_link_scheduler.md
# tx_link_scheduler

Sequences the shared per-lane TX datapath of the PCIe PHY among three sources: LTSSM training ordered sets, periodic SKP ordered sets, and LPIF TLP/DLLP data beats. Sits between the LTSSM/LPIF front end and the TX lane muxes. Drives `pl_trdy` toward the link layer and a source-select code toward the lane datapath. Guarantees that a SKP or ordered set never splits a packet.

## Interface
- `SKP_INTERVAL`, 1180: clocks between scheduled SKP ordered sets.
- `SKP_CYCLES`, 1: clocks one SKP ordered set occupies on the datapath.
- `OS_CYCLES`, 4: clocks one training ordered set occupies (16 symbols at 32-bit PIPE).
- `CNT_W`, 12: width of the interval counter; must hold `SKP_INTERVAL`.

Ports:
- `CLK`  in  1  PCLK; one clock domain. Already decided.
- `lpreset`  in  1  asynchronous, active-low reset. Already decided.
- `linkUp`  in  1  from LTSSM; high once the link is in L0.
- `os_req`  in  1  LTSSM requests the next training ordered set; held until `os_gnt`.
- `lp_irdy`  in  1  LPIF beat valid.
- `lp_pkt_start`  in  1  current beat starts a TLP/DLLP (OR of `lp_tlpstart`/`lp_dlpstart`).
- `lp_pkt_end`  in  1  current beat ends a TLP/DLLP (OR of `lp_tlpend`/`lp_dlpend`).
- `pl_trdy`  out  1  datapath accepts the LPIF beat this cycle.
- `tx_sel`  out  2  0 = electrical idle, 1 = ordered set, 2 = SKP, 3 = data.
- `os_gnt`  out  1  one-cycle pulse on the first cycle of an ordered-set slot.
- `os_done`  out  1  one-cycle pulse on the last cycle of an ordered-set slot.
- `skp_insert`  out  1  one-cycle pulse on the first cycle of a SKP slot.

## Operation
- States:
  - IDLE: `tx_sel`=0.
  - OS: `tx_sel`=1, lasts `OS_CYCLES`.
  - SKP: `tx_sel`=2, lasts `SKP_CYCLES`.
  - DATA: `tx_sel`=3.
- `in_pkt` flag:
  - Set on an accepted beat (`lp_irdy & pl_trdy`) with `lp_pkt_start & !lp_pkt_end`.
  - Cleared on an accepted beat with `lp_pkt_end`.
  - Cleared when `linkUp` falls.
- Interval counter:
  - Increments every cycle when state is not IDLE.
  - Reaching `SKP_INTERVAL-1` sets `skp_pending`. The counter then saturates.
  - Entering SKP clears both the counter and `skp_pending`.
- Boundary: `bnd = !in_pkt`.
- Priority at a slot boundary (IDLE, last cycle of OS/SKP, or DATA with `bnd`):
  1. `skp_pending` and state is not IDLE → SKP.
  2. `os_req` → OS.
  3. `linkUp` → DATA.
  4. Otherwise → IDLE.
- `pl_trdy = (state==DATA) & linkUp & !(bnd & (skp_pending | os_req))`. This term is combinational from registers plus `os_req`/`linkUp`. The beat in the switch cycle is not accepted.
- `linkUp` falls in any state: `in_pkt` clears. The next state is OS if `os_req`, else IDLE. An in-flight OS or SKP slot completes first. A DATA packet is abandoned.
- `os_req` while DATA with `in_pkt`: deferred until the packet ends.
- `skp_pending` while `in_pkt`: deferred indefinitely. The counter stays saturated; no second SKP accumulates.
- Simultaneous `skp_pending` and `os_req`: SKP is granted first, then OS immediately after.

## Timing
- Reset (`lpreset`=0, asynchronous):
  - State IDLE; counter, `skp_pending` and `in_pkt` all 0.
  - All outputs 0.
- `os_gnt` coincides with the first OS cycle; `os_done` with cycle `OS_CYCLES`.
- If `os_req` is still high at `os_done`, the next OS slot starts the following cycle with no gap.
- Request-to-grant latency from IDLE is 1 clock: `os_req` registered → `os_gnt` the next cycle.
- From DATA at a boundary, `pl_trdy` drops in the same cycle. SKP or OS starts on the next cycle.
- When the last SKP/OS cycle is followed by DATA, `pl_trdy` rises the cycle after that last cycle.

## Structure
- Package `pcie_tx_sched_pkg`:
  - state enum (IDLE/OS/SKP/DATA);
  - `tx_sel` encodings `SEL_IDLE`/`SEL_OS`/`SEL_SKP`/`SEL_DATA`.
- Sub-module `skp_interval_timer`:
  - Contains the counter, saturation and `skp_pending`.
  - Inputs: `run` (state ≠ IDLE) and `clr` (SKP entry).
- The FSM, slot-length counter and `in_pkt` tracking live in the top.

## Test plan
- Reset mid-OS slot: assert `lpreset`=0 at OS cycle 2 → `tx_sel`=0, all pulses 0 immediately. After release, an `os_req` gets `os_gnt` 1 clock later.
- Training: `linkUp`=0, `os_req` held 3 slots → `os_gnt` every 4 clocks, `tx_sel`=1 continuously, `pl_trdy`=0 throughout.
- Periodic SKP with `SKP_INTERVAL`=16, `linkUp`=1, single-beat packets every cycle:
  - `skp_insert` every 17 clocks, with `pl_trdy`=0 in the switch cycle and during SKP;
  - no beats lost.
- SKP deferral: a 10-beat packet starts 2 clocks before `skp_pending` → SKP starts the cycle after the `lp_pkt_end` beat; `skp_insert` occurs exactly once.
- Collision: `skp_pending` and `os_req` together at a boundary → SKP (`SKP_CYCLES`=1), then `os_gnt` on the next cycle, then DATA.
- Link drop: `linkUp` falls at beat 3 of a 6-beat packet → `pl_trdy`=0 the same cycle, `in_pkt` clears, state IDLE (or OS if `os_req`=1).
